// File: rtl/imem_loader.sv
// imem_loader
// -----------------------------------------------------------------------------
// Boot-time loader for an RV32 instruction memory. A serial byte stream
// carries a 16-bit little-endian word count followed by that many 32-bit
// little-endian instruction words. Each complete word is written to the
// instruction memory with a one-cycle strobe. The core is held in reset
// until the whole program has been written.
//
// Parameters
//   MAX_WORDS  largest program size in 32-bit words accepted (<= 65535)
//   BASE_ADDR  byte address of the first instruction word written
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   byte_valid  byte_data holds a valid serial byte
//   byte_data   incoming program byte
//   byte_ready  loader can accept a byte this cycle
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   byte address of the word being written
//   imem_wdata  assembled instruction word
//   core_rst    holds the core in reset until the load completes
//   done        program fully written
//   error       header word count exceeded MAX_WORDS
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [15:0] MAX_WORDS_16 = 16'(MAX_WORDS);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_byteCnt;
    logic [15:0] r_wordIndex;
    logic [15:0] r_count;
    logic [31:0] r_word;

    logic        w_xfer;
    logic [15:0] w_hdrCount;
    logic [15:0] w_nextIndex;

    // The full word count only exists once the high header byte arrives,
    // so the HDR1 decision looks at the incoming byte directly.
    assign w_xfer      = byte_valid & byte_ready;
    assign w_hdrCount  = {byte_data, r_count[7:0]};
    assign w_nextIndex = r_wordIndex + 16'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HDR0;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. DONE and ERROR only leave through reset.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HDR0: begin
                if (w_xfer) begin
                    w_nextState = HDR1;
                end
            end
            HDR1: begin
                if (w_xfer) begin
                    if (w_hdrCount > MAX_WORDS_16) begin
                        w_nextState = ERROR;
                    end else if (w_hdrCount == 16'd0) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = LOAD;
                    end
                end
            end
            LOAD: begin
                if (w_xfer && (r_byteCnt == 2'd3)) begin
                    w_nextState = WRITE;
                end
            end
            WRITE: begin
                if (w_nextIndex == r_count) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = LOAD;
                end
            end
            DONE:    w_nextState = DONE;
            ERROR:   w_nextState = ERROR;
            default: w_nextState = HDR0;
        endcase
    end

    // Outputs decoded from the current state. Address and data are always
    // driven from the index and word registers; at reset both are zero so
    // the bus shows BASE_ADDR and 0.
    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        core_rst   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        imem_addr  = BASE_ADDR + {14'd0, r_wordIndex, 2'b00};
        imem_wdata = r_word;
        case (r_state)
            HDR0, HDR1, LOAD: byte_ready = 1'b1;
            WRITE:            imem_we    = 1'b1;
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            ERROR:            error      = 1'b1;
            default:          byte_ready = 1'b0;
        endcase
    end

    // Header capture, little-endian word assembly and word indexing.
    // The byte counter wraps 3->0 on its own, so a new word always starts
    // at lane 0 without an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byteCnt   <= 2'd0;
            r_wordIndex <= 16'd0;
            r_count     <= 16'd0;
            r_word      <= 32'd0;
        end else begin
            case (r_state)
                HDR0: begin
                    if (w_xfer) begin
                        r_count[7:0] <= byte_data;
                    end
                end
                HDR1: begin
                    if (w_xfer) begin
                        r_count[15:8] <= byte_data;
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        r_word[{r_byteCnt, 3'b000} +: 8] <= byte_data;
                        r_byteCnt                        <= r_byteCnt + 2'd1;
                    end
                end
                WRITE: begin
                    r_wordIndex <= w_nextIndex;
                end
                default: begin
                    r_byteCnt <= r_byteCnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// -----------------------------------------------------------------------------
// Testbench for imem_loader. Directed byte streams are driven on the falling
// edge; expected memory writes are queued as each word is issued and a
// separate monitor pops and compares them whenever imem_we is seen.
// Status outputs are compared directly at the points of interest.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [63:0] expQ[$];

    imem_loader #(
        .MAX_WORDS(256),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor: every write strobe must match the oldest queued
    // expectation of {address, data}.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (imem_we === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected write: addr=%h data=%h, required no write",
                         imem_addr, imem_wdata);
            end else begin
                exp = expQ.pop_front();
                if ({imem_addr, imem_wdata} !== exp) begin
                    errors++;
                    $display("[TB] FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_wdata, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data);
        expQ.push_back({addr, data});
    endtask

    // Idle for gap cycles with junk on the data bus, then present one byte
    // and hold it until a transfer edge has occurred. Called and returns on
    // a falling edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        logic rdy;
        bit   sent;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        sent       = 1'b0;
        for (int t = 0; t < 50 && !sent; t++) begin
            rdy = byte_ready;
            @(negedge clk);
            if (rdy) sent = 1'b1;
        end
        if (!sent) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte accept timeout: byte %h never accepted, required accept", b);
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " byte_ready"}, 32'(byte_ready), 32'd1);
        checkOutput({tag, " imem_we"},    32'(imem_we),    32'd0);
        checkOutput({tag, " imem_addr"},  imem_addr,       32'h0);
        checkOutput({tag, " imem_wdata"}, imem_wdata,      32'h0);
        checkOutput({tag, " core_rst"},   32'(core_rst),   32'd1);
        checkOutput({tag, " done"},       32'(done),       32'd0);
        checkOutput({tag, " error"},      32'(error),      32'd0);
    endtask

    task automatic doReset();
        byte_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("post-reset");
    endtask

    // Hold byte_valid high with junk for n cycles while the loader is in a
    // terminal state; nothing may be written or change.
    task automatic junkBytes(input int n);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    logic [7:0] s1[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                           8'h93, 8'h00, 8'hA0, 8'h00};
    logic [7:0] s3w[14] = '{8'h03, 8'h00,
                            8'h01, 8'h02, 8'h03, 8'h04,
                            8'hAA, 8'hBB, 8'hCC, 8'hDD,
                            8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] s4[4]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int         gaps[4] = '{1, 2, 0, 3};

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Two-word back-to-back program.
        doReset();
        pushWrite(32'h0, 32'h0050_0013);
        pushWrite(32'h4, 32'h00A0_0093);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) byte_valid = 1'b1;
            applyStimulus(s1[i], 0);
        end
        checkOutput("two-word done during last write", 32'(done), 32'd0);
        checkOutput("two-word core_rst during last write", 32'(core_rst), 32'd1);
        @(negedge clk);
        checkOutput("two-word done", 32'(done), 32'd1);
        checkOutput("two-word core_rst", 32'(core_rst), 32'd0);
        checkOutput("two-word byte_ready in DONE", 32'(byte_ready), 32'd0);
        junkBytes(4);
        checkOutput("two-word done held", 32'(done), 32'd1);
        checkOutput("two-word error", 32'(error), 32'd0);

        // Three words to exercise the index beyond 1.
        doReset();
        pushWrite(32'h0, 32'h0403_0201);
        pushWrite(32'h4, 32'hDDCC_BBAA);
        pushWrite(32'h8, 32'h1234_5678);
        for (int i = 0; i < 14; i++) applyStimulus(s3w[i], 0);
        @(negedge clk);
        checkOutput("three-word done", 32'(done), 32'd1);

        // Zero-length header.
        doReset();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkOutput("zero-count done", 32'(done), 32'd1);
        checkOutput("zero-count core_rst", 32'(core_rst), 32'd0);
        checkOutput("zero-count byte_ready", 32'(byte_ready), 32'd0);
        junkBytes(3);
        checkOutput("zero-count byte_ready held", 32'(byte_ready), 32'd0);

        // Count 257 exceeds MAX_WORDS.
        doReset();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h01, 0);
        checkOutput("oversize error", 32'(error), 32'd1);
        checkOutput("oversize byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("oversize core_rst", 32'(core_rst), 32'd1);
        checkOutput("oversize done", 32'(done), 32'd0);
        junkBytes(4);
        checkOutput("oversize error held", 32'(error), 32'd1);

        // Count 256 is exactly MAX_WORDS and must be accepted; interrupt the
        // load with an asynchronous reset after two word bytes.
        doReset();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        checkOutput("max-count error", 32'(error), 32'd0);
        checkOutput("max-count byte_ready", 32'(byte_ready), 32'd1);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        #3;
        rst = 1'b1;
        #1;
        checkResetOutputs("async reset");
        @(negedge clk);
        checkResetOutputs("async reset held");
        rst = 1'b0;
        pushWrite(32'h0, 32'h1122_3344);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h44, 0);
        applyStimulus(8'h33, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h11, 0);
        @(negedge clk);
        checkOutput("reload done", 32'(done), 32'd1);

        // One word with gaps in byte_valid, valid held high through WRITE.
        doReset();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 1);
        pushWrite(32'h0, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) applyStimulus(s4[i], gaps[i]);
        checkOutput("gapped write strobe", 32'(imem_we), 32'd1);
        junkBytes(3);
        checkOutput("gapped done", 32'(done), 32'd1);
        checkOutput("gapped imem_we after", 32'(imem_we), 32'd0);

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: MAX_WORDS, 256, largest program size in 32-bit words accepted.
REQ-002 SHALL have parameter: BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: byte_valid  input  1  byte_data holds a valid serial byte.
REQ-006 SHALL have port: byte_data  input  8  incoming program byte.
REQ-007 SHALL have port: byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port: imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port: imem_addr  output  32  byte address of the word being written.
REQ-010 SHALL have port: imem_wdata  output  32  assembled instruction word.
REQ-011 SHALL have port: core_rst  output  1  holds the RV32 core in reset until the load completes.
REQ-012 SHALL have port: done  output  1  program fully written.
REQ-013 SHALL have port: error  output  1  header word count exceeded MAX_WORDS.

Function
REQ-014 SHALL transfer a byte only on a cycle where byte_valid and byte_ready are both 1; byte_data is ignored on all other cycles.
REQ-015 SHALL implement states HDR0, HDR1, LOAD, WRITE, DONE and ERROR.
REQ-016 SHALL drive byte_ready=1 in HDR0, HDR1 and LOAD, and byte_ready=0 in WRITE, DONE and ERROR.
REQ-017 SHALL take the first transferred byte as word-count bits [7:0] (HDR0->HDR1) and the second as bits [15:8] (HDR1->next).
REQ-018 On the HDR1 transfer: count>MAX_WORDS SHALL go to ERROR; count==0 SHALL go to DONE; otherwise SHALL go to LOAD.
REQ-019 SHALL assemble each word little-endian: byte k of the word (k=0..3) lands in bits [8k+7:8k].
REQ-020 SHALL use a 2-bit byte counter, wrapping 3->0 on the fourth byte transfer; that transfer SHALL move LOAD->WRITE.
REQ-021 In WRITE (exactly one cycle) SHALL drive imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR+4*word_index (32-bit, modulo 2^32).
REQ-022 SHALL drive imem_we=0 in every state other than WRITE; imem_addr and imem_wdata are don't-care when imem_we=0.
REQ-023 After WRITE SHALL increment word_index; if word_index+1==count SHALL go to DONE, else SHALL go to LOAD.
REQ-024 Latency: the fourth byte transferred at edge N SHALL produce imem_we=1 in the cycle after edge N; for the last word, done=1 and core_rst=0 from the following edge.
REQ-025 SHALL drive core_rst=1 in all states except DONE; core_rst=0 and done=1 only in DONE.
REQ-026 SHALL drive error=1 only in ERROR; ERROR and DONE SHALL be terminal until rst.
REQ-027 Gaps in byte_valid SHALL stall the loader with no loss or duplication of bytes; partial words SHALL be held indefinitely.
REQ-028 SHALL size word_index and count at 16 bits; MAX_WORDS SHALL be at most 65535.

Reset
REQ-029 While rst=1 (asynchronously, including mid-load) SHALL force state=HDR0, byte counter=0, word_index=0, count=0 and assembled word=0.
REQ-030 During and after reset SHALL output byte_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_rst=1, done=0, error=0.
REQ-031 A reload after rst deassertion SHALL restart from the header, overwriting from BASE_ADDR.

Verification
REQ-032 Bytes 02 00 13 00 50 00 93 00 A0 00 back-to-back -> imem_we pulses write 0x00500013@0x0 then 0x00A00093@0x4; done=1, core_rst=0 two cycles after the last byte.
REQ-033 Header 00 00 -> no imem_we pulses; done=1 and core_rst=0 the cycle after the second byte; byte_ready=0 thereafter.
REQ-034 Header 01 01 (257) with MAX_WORDS=256 -> error=1, byte_ready=0, core_rst=1, no writes; extra bytes are ignored.
REQ-035 One-word load with byte_valid toggled 1,0,0,1,… and byte_valid held high during WRITE -> exactly one write of the correct word, no byte lost or duplicated.
REQ-036 rst pulsed after 2 of 4 word bytes, then a fresh 1-word stream -> first write at BASE_ADDR with the new word only; all outputs at reset values during rst.
